// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC operand feeder.
// Every width in the feeder and its FIFO is derived from here.
package mac_pkg;

    localparam int unsigned OP_W  = 12;
    localparam int unsigned ACC_W = 25;
    localparam int unsigned ENT_W = 2 * OP_W + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StDrain  = 2'd2,
        StResult = 2'd3
    } state_e;

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand-pair FIFO. Each pointer carries an extra MSB so that a
// full FIFO can be told apart from an empty one.
module op_fifo
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// Buffers operand pairs, streams one vector at a time into an external
// multiply-accumulate unit and captures its sum once the vector has ended.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               init_q;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENT_W-1:0]   fifo_rdata;
    logic               head_last;
    logic [OP_W-1:0]    head_a, head_b;

    assign {head_last, head_a, head_b} = fifo_rdata;

    // init_q keeps in_ready low until the first edge after reset releases.
    assign in_ready = init_q && !fifo_full;

    op_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_op_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .wdata   ({in_last, in_a, in_b}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        fifo_pop    = 1'b0;
        mac_a       = '0;
        mac_b       = '0;
        mac_clr     = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                end
            end
            StAccum: begin
                mac_clr = 1'b0;
                // An empty FIFO leaves zeros on the operands so the sum holds.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mac_a    = head_a;
                    mac_b    = head_b;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (head_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                mac_clr     = 1'b0;
                res_data_d  = mac_sum;
                res_count_d = cnt_q;
                res_valid_d = 1'b1;
                state_d     = StResult;
            end
            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            init_q      <= 1'b1;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: directed vectors plus a randomized phase, checked
// against a per-vector dot-product model fed from observed input transfers.
module tb_mac_feeder;
    import mac_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OP_W-1:0]  in_a = '0;
    logic [OP_W-1:0]  in_b = '0;
    logic             in_last = 1'b0;
    logic [OP_W-1:0]  mac_a, mac_b;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_sum = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned cur_sum = 0;
    int unsigned cur_cnt = 0;
    int unsigned exp_sum[$];
    int unsigned exp_cnt[$];

    bit hold_done = 1'b0;
    bit rand_done = 1'b0;

    always #5 clk = ~clk;

    mac_feeder #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_clr   (mac_clr),
        .mac_sum   (mac_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    // Accumulator the feeder drives.
    always @(posedge clk) begin
        mac_sum <= mac_clr ? '0 : mac_sum + ACC_W'(mac_a) * ACC_W'(mac_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: sampled at negedge, the transfers happen on the next posedge.
    always @(negedge clk) begin
        if (!reset_n) begin
            cur_sum = 0;
            cur_cnt = 0;
            exp_sum.delete();
            exp_cnt.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (exp_sum.size() == 0) begin
                    check("unexpected_result", 32'(res_data), 32'hffff_ffff);
                end else begin
                    check("res_data", 32'(res_data), exp_sum.pop_front());
                    check("res_count", 32'(res_count), exp_cnt.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                cur_sum = (cur_sum + 32'(in_a) * 32'(in_b)) % 32'h0200_0000;
                if (cur_cnt < 255) cur_cnt++;
                if (in_last) begin
                    exp_sum.push_back(cur_sum);
                    exp_cnt.push_back(cur_cnt);
                    cur_sum = 0;
                    cur_cnt = 0;
                end
            end
        end
    end

    // Returns at posedge+2 right after the edge that transferred the pair.
    task automatic push(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_sum.size() == 0 && !res_valid) break;
        end
        check("drain", 32'(exp_sum.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mac_clr", 32'(mac_clr), 32'd1);
        check("rst_mac_a", 32'(mac_a), 32'd0);
        check("rst_mac_b", 32'(mac_b), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        check("rdy_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rdy_after_edge", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // Single pair, latency E+3
        push(12'd3, 12'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("lat_e%0d", i), 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_e3", 32'(res_valid), 32'd1);
        check("lat_data", 32'(res_data), 32'd15);
        @(posedge clk);
        #2;
        wait_drain();

        // Back-to-back vector
        for (int i = 1; i <= 4; i++) push(12'(i), 12'(i), i == 4);
        wait_drain();

        // Wrapping sums
        push(12'd4095, 12'd4095, 1'b0);
        push(12'd4095, 12'd4095, 1'b1);
        wait_drain();
        push(12'd4095, 12'd4095, 1'b0);
        push(12'd4095, 12'd4095, 1'b0);
        push(12'd4095, 12'd4095, 1'b1);
        wait_drain();

        // Gap inside a vector: bubbles must be zero and must not clear
        push(12'd2, 12'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 1) check("gap_clr", 32'(mac_clr), 32'd0);
            if (i >= 2) begin
                check("gap_a", 32'(mac_a), 32'd0);
                check("gap_b", 32'(mac_b), 32'd0);
            end
        end
        @(posedge clk);
        #2;
        push(12'd4, 12'd5, 1'b1);
        wait_drain();

        // Held result with FIFO filling behind it
        res_ready = 1'b0;
        push(12'd5, 12'd6, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        @(posedge clk);
        #2;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    push(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), k == 5);
                end
                hold_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'd30);
            check("hold_count", 32'(res_count), 32'd1);
        end
        check("hold_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        for (int i = 0; i < 200 && !hold_done; i++) @(posedge clk);
        check("hold_pushes_done", 32'(hold_done), 32'd1);
        #2;
        wait_drain();

        // Reset in the middle of a vector
        push(12'd1, 12'd2, 1'b0);
        push(12'd3, 12'd4, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_clr", 32'(mac_clr), 32'd1);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_mac_a", 32'(mac_a), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_empty", 32'(mac_clr), 32'd1);
        @(posedge clk);
        #2;
        push(12'd7, 12'd7, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check("post_rst_data", 32'(res_data), 32'd49);
        check("post_rst_count", 32'(res_count), 32'd1);
        wait_drain();

        // Randomized vectors with random backpressure
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2;
                    if (!rand_done) res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int v = 0; v < 30; v++) begin
            int unsigned len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < int'(len); k++) begin
                push(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), k == int'(len) - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #2;
                end
            end
        end
        rand_done = 1'b1;
        @(posedge clk);
        #3;
        res_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of operand-pair entries buffered; it SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default 8, sets the width of the per-vector element counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low; the ports are clk and reset_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  the upstream operand pair is valid.
REQ-007 in_ready  output  1  the block can accept a pair.
REQ-008 in_a  input  12  operand A, unsigned.
REQ-009 in_b  input  12  operand B, unsigned.
REQ-010 in_last  input  1  this pair ends the current dot-product vector.
REQ-011 mac_a  output  12  operand A to the multiply-accumulate unit.
REQ-012 mac_b  output  12  operand B to the multiply-accumulate unit.
REQ-013 mac_clr  output  1  active-high synchronous clear to the multiply-accumulate unit.
REQ-014 mac_sum  input  25  registered accumulator value from the multiply-accumulate unit.
REQ-015 res_valid  output  1  the result is valid.
REQ-016 res_ready  input  1  downstream accepts the result.
REQ-017 res_data  output  25  dot-product result.
REQ-018 res_count  output  CNT_W  number of pairs in the vector, saturating.

Function
REQ-019 The input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; the pair {in_a, in_b, in_last} SHALL be pushed into the FIFO.
REQ-020 in_ready SHALL equal "FIFO not full" and SHALL not depend on a same-cycle pop (no pass-through when full).
REQ-021 The FSM SHALL have four states: IDLE, ACCUM, DRAIN and RESULT.
REQ-022 IDLE: mac_clr=1 and mac_a=mac_b=0; if the FIFO is not empty, the FSM SHALL go to ACCUM and clear the counter to 0.
REQ-023 ACCUM: mac_clr=0; if the FIFO is not empty, the block SHALL drive the head entry on mac_a/mac_b, pop it and increment the counter (saturating at 2^CNT_W-1); if the FIFO is empty, it SHALL drive mac_a=mac_b=0 (a bubble, so the accumulator holds).
REQ-024 ACCUM to DRAIN SHALL occur on the edge that pops an entry with last=1.
REQ-025 DRAIN lasts one cycle: mac_clr=0 and mac_a=mac_b=0; at the end of the cycle, res_data<=mac_sum, res_count<=counter, res_valid<=1, and the FSM goes to RESULT.
REQ-026 RESULT: mac_clr=1 and mac_a=mac_b=0; res_valid, res_data and res_count SHALL stay stable until res_valid&&res_ready; on that edge, res_valid<=0 and the FSM goes to IDLE.
REQ-027 The FIFO SHALL keep accepting input in every state while not full.
REQ-028 mac_a and mac_b SHALL be combinational from the FSM state and the FIFO head; no operand is issued outside ACCUM.
REQ-029 The result width SHALL be 25 bits; accumulation wraps modulo 2^25 (the accumulator behaviour) and the block SHALL pass mac_sum through unchanged.
REQ-030 Latency: with an empty FIFO and res_ready=1, a single last=1 pair accepted at edge E SHALL produce res_valid=1 after edge E+3.
REQ-031 A vector whose first pair has last=1 SHALL yield res_count=1.

Reset
REQ-032 While reset_n=0: FSM=IDLE, FIFO empty, counter=0, res_valid=0, res_data=0, res_count=0, in_ready=0, mac_clr=1, mac_a=mac_b=0.
REQ-033 Reset asserted in any state SHALL discard the FIFO contents and any partial vector.
REQ-034 in_ready SHALL rise on the first edge after reset_n deasserts.

Structure
REQ-035 Package mac_pkg SHALL hold OP_W=12, ACC_W=25 and the FSM state enum; all widths SHALL be taken from it.
REQ-036 The FIFO SHALL be a sub-module op_fifo: synchronous, width 2*OP_W+1, depth FIFO_DEPTH, with full/empty flags and wrap-around pointers that carry an extra MSB.

Verification
REQ-037 Verification SHALL cover the following directed scenarios, each against a behavioural accumulator model (sum_reg <= clr ? 0 : sum_reg + a*b):
- One pair (3,5,last) -> res_data=15, res_count=1, res_valid after edge E+3.
- Pairs (1,1),(2,2),(3,3),(4,4,last), back-to-back -> res_data=30, res_count=4.
- Pairs (4095,4095),(4095,4095,last) -> 33538050; three such pairs -> 16752643 (wrapped).
- Pairs (2,3),(gap of 5 cycles),(4,5,last) -> bubbles drive zeros; res_data=26, res_count=2.
- res_ready=0 for 10 cycles with 6 further pairs offered -> result held stable; FIFO fills to 4; in_ready=0 until the result drains.
- reset_n pulsed low mid-ACCUM -> res_valid=0, mac_clr=1, FIFO empty; the next vector (7,7,last) -> 49.
